seek_sequencer: RTL
===================

SEEK_SEQUENCER -- requirements
Module: seek_sequencer

Interface
REQ-001 Parameter STEP_CYCLES, default 4: clk cycles per one-cylinder head step; legal range 1 or more.
REQ-002 Parameter SETTLE_CYCLES, default 25: head settle time after the last step; legal range 1 or more.
REQ-003 Parameter MAX_CYL, default 407: highest legal cylinder address.
REQ-004 Port clk, input, 1: sole clock; all logic is on the rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port en, input, 1: drive selected; when low, seek_req and rtz_req are ignored.
REQ-007 Port seek_req, input, 1: one-cycle seek request pulse (from the seek-strobe logic).
REQ-008 Port target_cyl, input, 9: requested cylinder; valid when seek_req=1.
REQ-009 Port rtz_req, input, 1: one-cycle return-to-zero pulse.
REQ-010 Port cur_cyl, output, 9: current head cylinder.
REQ-011 Port on_cyl, output, 1: heads settled on a cylinder; read/write permitted.
REQ-012 Port busy, output, 1: high in MOVE or SETTLE.
REQ-013 Port seek_error, output, 1: the last consumed seek had target_cyl > MAX_CYL.
REQ-014 Port step, output, 1: one-cycle pulse per cylinder moved.
REQ-015 Port dir, output, 1: 1 = toward higher cylinders, 0 = toward lower; held between seeks.

Function
REQ-016 The block SHALL be an FSM with states IDLE, MOVE, SETTLE and ERROR; all outputs are registered.
REQ-017 An accepted request at edge E0 with a legal target and distance d = |target - cur_cyl| SHALL produce the following at E0: busy=1, on_cyl=0, dir set, seek_error=0, and state MOVE if d>0 or SETTLE if d=0.
REQ-018 In MOVE, at edge E0 + k*STEP_CYCLES for k = 1..d, cur_cyl SHALL change by +/-1 and step SHALL be 1 for exactly that one cycle.
REQ-019 When cur_cyl reaches the target, the FSM SHALL enter SETTLE and hold it for SETTLE_CYCLES cycles; on_cyl=1 and busy=0 at edge E0 + d*STEP_CYCLES + SETTLE_CYCLES.
REQ-020 Distance SHALL be computed as 9-bit unsigned magnitude with no wrap; cur_cyl SHALL never leave the range 0..MAX_CYL.
REQ-021 A seek_req with target_cyl > MAX_CYL, when consumed, SHALL cause: state ERROR, seek_error=1, on_cyl=1, busy=0, cur_cyl unchanged, no step pulses.
REQ-022 ERROR SHALL be left only by a subsequent legal seek_req or an rtz_req, handled as in IDLE.
REQ-023 A seek_req arriving in MOVE or SETTLE SHALL be stored in a one-entry pending slot; a later request overwrites an earlier one.
REQ-024 At SETTLE completion with the pending slot full, the pending request SHALL be consumed at that same edge; on_cyl stays 0 and the slot is cleared.
REQ-025 An rtz_req in any state SHALL retarget to cylinder 0 immediately, restart the step timer, clear the pending slot and clear seek_error.
REQ-026 When rtz_req and seek_req occur in the same cycle, rtz_req SHALL win and the seek SHALL be discarded.
REQ-027 A seek_req at the same edge as SETTLE completion SHALL be consumed directly, as if pending.
REQ-028 With en=0, requests SHALL be dropped; a seek already in progress SHALL complete normally.

Reset
REQ-029 rst=1 SHALL set: state IDLE, cur_cyl=0, on_cyl=1, busy=0, seek_error=0, step=0, dir=0, pending slot empty, timers 0.
REQ-030 Reset SHALL take priority over every request and SHALL abort motion mid-seek with no further step pulses.

Structure
REQ-031 The shared package hawk_pkg SHALL hold the cyl_t typedef (9-bit), MAX_CYL_DEFAULT=407 and the seek_state_t enum.
REQ-032 The step and settle countdown SHALL be a sub-module seek_step_timer (load, count, done pulse); the FSM and pending slot stay in seek_sequencer.

Verification (STEP_CYCLES=4, SETTLE_CYCLES=25)
REQ-033 Case 1: from reset, seek_req target=3 at E0 -> step at E0+4, +8, +12; cur_cyl = 1, 2, 3; on_cyl=1 at E0+37.
REQ-034 Case 2: at cylinder 10, seek_req target=10 -> no step pulse; on_cyl low for 25 cycles; dir unchanged.
REQ-035 Case 3: seek_req target=408 -> seek_error=1, on_cyl=1, cur_cyl unchanged; then rtz_req -> seek_error=0 and the seek to 0 runs.
REQ-036 Case 4: seek to 100, then seek_req 50 followed by seek_req 20 mid-MOVE -> after settling at 100, the seek to 20 starts at the same edge (80 steps down); the request for 50 is never executed.
REQ-037 Case 5: rtz_req and seek_req(200) in the same cycle while at 5 -> heads move to 0; the request for 200 is never executed.
REQ-038 Case 6: rst asserted mid-MOVE -> next cycle cur_cyl=0, on_cyl=1, busy=0, no step pulses.

Source files
------------

// File: rtl/hawk_pkg.sv
// hawk_pkg: shared cylinder type, default geometry and seek FSM states.
package hawk_pkg;
    typedef logic [8:0] cyl_t;
    localparam int MAX_CYL_DEFAULT = 407;
    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_SETTLE, S_ERROR} seek_state_t;
endpackage

// File: rtl/seek_sequencer_if.sv
// seek_sequencer_if: request/status bundle between the drive controller and the seek sequencer.
interface seek_sequencer_if;
    import hawk_pkg::*;
    logic en;
    logic seek_req;
    logic rtz_req;
    cyl_t target_cyl;
    cyl_t cur_cyl;
    logic on_cyl;
    logic busy;
    logic seek_error;
    logic step;
    logic dir;
    modport master (output en, seek_req, rtz_req, target_cyl,
                    input cur_cyl, on_cyl, busy, seek_error, step, dir);
    modport slave (input en, seek_req, rtz_req, target_cyl,
                   output cur_cyl, on_cyl, busy, seek_error, step, dir);
endinterface

// File: rtl/seek_step_timer.sv
// seek_step_timer: loadable down-counter; done_o is high for the single cycle the count sits at 1.
module seek_step_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         done_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? val_i : (cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
    assign done_o = cnt_q == W'(1);
endmodule

// File: rtl/seek_sequencer.sv
// seek_sequencer: head positioner FSM stepping one cylinder per STEP_CYCLES, then settling.
// Holds a one-entry pending seek that is launched at the edge the current settle completes.
module seek_sequencer
    import hawk_pkg::*;
#(
    parameter int STEP_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 25,
    parameter int MAX_CYL       = MAX_CYL_DEFAULT
) (
    input logic             clk,
    input logic             rst,
    seek_sequencer_if.slave bus
);
    localparam int TW = $clog2((STEP_CYCLES > SETTLE_CYCLES ? STEP_CYCLES : SETTLE_CYCLES) + 1);
    localparam cyl_t MAX_C = cyl_t'(MAX_CYL);
    localparam logic [TW-1:0] STEP_LD   = TW'(STEP_CYCLES);
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES);

    seek_state_t   state_q, state_d;
    cyl_t          cur_q, cur_d, tgt_q, tgt_d, pend_q, pend_d, start_cyl, next_cyl;
    logic          pend_v_q, pend_v_d, on_q, on_d, busy_q, busy_d;
    logic          err_q, err_d, step_q, step_d, dir_q, dir_d;
    logic          req, rtz, settle_done, start, ld, t_done;
    logic [TW-1:0] ld_val;

    seek_step_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (ld),
        .val_i  (ld_val),
        .done_o (t_done)
    );

    assign req         = bus.en & bus.seek_req;
    assign rtz         = bus.en & bus.rtz_req;
    assign settle_done = (state_q == S_SETTLE) & t_done;
    // rtz beats a simultaneous seek; a fresh seek at settle completion overrides the pending one
    assign start       = rtz | (req & (state_q == S_IDLE || state_q == S_ERROR || settle_done))
                       | (settle_done & pend_v_q);
    assign start_cyl   = rtz ? '0 : req ? bus.target_cyl : pend_q;
    assign next_cyl    = dir_q ? cur_q + 9'd1 : cur_q - 9'd1;

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        tgt_d    = tgt_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        on_d     = on_q;
        busy_d   = busy_q;
        err_d    = err_q;
        dir_d    = dir_q;
        step_d   = 1'b0;
        ld       = 1'b0;
        ld_val   = STEP_LD;
        if (start) begin
            pend_v_d = 1'b0;
            if (!rtz && start_cyl > MAX_C) begin
                state_d = S_ERROR;
                err_d   = 1'b1;
                on_d    = 1'b1;
                busy_d  = 1'b0;
            end else begin
                err_d   = 1'b0;
                on_d    = 1'b0;
                busy_d  = 1'b1;
                tgt_d   = start_cyl;
                ld      = 1'b1;
                state_d = (start_cyl == cur_q) ? S_SETTLE : S_MOVE;
                ld_val  = (start_cyl == cur_q) ? SETTLE_LD : STEP_LD;
                dir_d   = (start_cyl == cur_q) ? dir_q : start_cyl > cur_q;
            end
        end else begin
            if (req) begin
                pend_v_d = 1'b1;
                pend_d   = bus.target_cyl;
            end
            if (state_q == S_MOVE && t_done) begin
                cur_d   = next_cyl;
                step_d  = 1'b1;
                ld      = 1'b1;
                state_d = (next_cyl == tgt_q) ? S_SETTLE : S_MOVE;
                ld_val  = (next_cyl == tgt_q) ? SETTLE_LD : STEP_LD;
            end
            if (settle_done) begin
                state_d = S_IDLE;
                on_d    = 1'b1;
                busy_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cur_q    <= '0;
            tgt_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            on_q     <= 1'b1;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            tgt_q    <= tgt_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            on_q     <= on_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
        end
    end

    assign bus.cur_cyl    = cur_q;
    assign bus.on_cyl     = on_q;
    assign bus.busy       = busy_q;
    assign bus.seek_error = err_q;
    assign bus.step       = step_q;
    assign bus.dir        = dir_q;
endmodule
